// File: rtl/apb3_completer_synth_pkg.sv
// rtl/apb3_completer_synth_pkg.sv - shared types and sizing helpers for the APB3 completer
package apb3_completer_synth_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int ErrCountWidth = 8;

  // Byte-offset bits below the word index (0 for 8-bit data).
  function automatic int lsb_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Width of the word index into the register memory.
  function automatic int idx_bits(input int mem_depth);
    return $clog2(mem_depth);
  endfunction

endpackage

// File: rtl/apb3_completer_mem.sv
// rtl/apb3_completer_mem.sv - register array with one write port and one combinational read port
module apb3_completer_mem
  import apb3_completer_synth_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int MemDepth  = 16,
  localparam int IdxW     = idx_bits(MemDepth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [IdxW-1:0]      waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [IdxW-1:0]      raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [MemDepth];

  // Every word is cleared on reset so a reset mid-transfer leaves no stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MemDepth; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb3_completer_synth.sv
// rtl/apb3_completer_synth.sv - APB3 completer with register memory, wait states and error response
module apb3_completer_synth
  import apb3_completer_synth_pkg::*;
#(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int MemDepth     = 16,
  parameter int WaitStates   = 0
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic [AddressWidth-1:0]  paddr,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [DataWidth-1:0]     pwdata,
  output logic                     pready,
  output logic [DataWidth-1:0]     prdata,
  output logic                     pslverr,
  output logic [ErrCountWidth-1:0] err_count
);

  localparam int Lsb      = lsb_bits(DataWidth);
  localparam int IdxW     = idx_bits(MemDepth);
  localparam int MemBytes = MemDepth * DataWidth / 8;
  localparam logic [AddressWidth-1:0] AlignMask = AddressWidth'((1 << Lsb) - 1);
  localparam logic [AddressWidth:0]   LimitAddr = (AddressWidth + 1)'(MemBytes);

  state_e               state, state_d;
  logic [3:0]           wcnt;
  logic [IdxW-1:0]      lat_idx;
  logic                 lat_write;
  logic                 lat_err;
  logic [DataWidth-1:0] lat_wdata;

  logic                 setup, tick, ready_set, complete, abort;
  logic                 setup_err, cur_err, cur_write;
  logic [IdxW-1:0]      setup_idx, rd_idx;
  logic [DataWidth-1:0] rd_data;

  assign setup_idx = paddr[Lsb +: IdxW];
  assign setup_err = (|(paddr & AlignMask)) || ({1'b0, paddr} >= LimitAddr);
  assign cur_err   = setup ? setup_err : lat_err;
  assign cur_write = setup ? pwrite    : lat_write;
  assign rd_idx    = setup ? setup_idx : lat_idx;

  // Next-state and per-edge control decode; outputs themselves are registered below.
  always_comb begin
    state_d   = state;
    setup     = 1'b0;
    tick      = 1'b0;
    ready_set = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        // psel with penable and no prior setup is ignored.
        if (psel && !penable) begin
          setup     = 1'b1;
          state_d   = ACCESS;
          ready_set = (WaitStates == 0);
        end
      end
      ACCESS: begin
        if (!psel) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (pready) begin
          if (penable) begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          tick      = 1'b1;
          ready_set = (wcnt <= 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_d;
  end

  // Setup latches, wait counter, registered response and saturating error counter.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wcnt      <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_wdata <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
      err_count <= '0;
    end else begin
      if (setup) begin
        lat_idx   <= setup_idx;
        lat_write <= pwrite;
        lat_err   <= setup_err;
        lat_wdata <= pwdata;
        wcnt      <= 4'(WaitStates);
      end else if (tick && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end

      if (ready_set) begin
        pready  <= 1'b1;
        pslverr <= cur_err;
        prdata  <= (!cur_write && !cur_err) ? rd_data : '0;
      end else if (complete || abort) begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
        prdata  <= '0;
      end

      if (complete && lat_err && err_count != {ErrCountWidth{1'b1}}) begin
        err_count <= err_count + ErrCountWidth'(1);
      end
    end
  end

  apb3_completer_mem #(
    .DataWidth (DataWidth),
    .MemDepth  (MemDepth)
  ) u_mem (
    .clk   (pclk),
    .rst_n (presetn),
    .we    (complete && lat_write && !lat_err),
    .waddr (lat_idx),
    .wdata (lat_wdata),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

endmodule

// File: doc/apb3_completer_synth.md
Name: apb3_completer_synth

Overview:
- Synthesizable APB3 completer: the responder end for APB3 requesters such as apb3_requester_synth and renode_apb3_requester.
- Holds a small word-addressed register memory, inserts a fixed number of wait states, and flags bad accesses with pslverr.
- Lets Renode-driven or synthesized requesters be co-simulated against real RTL instead of a Renode-side completer.

Parameters:
- AddressWidth, 32, paddr width.
- DataWidth, 32, pwdata/prdata width; must be 8, 16 or 32.
- MemDepth, 16, number of DataWidth words; power of two, at least 2.
- WaitStates, 0, pready-low cycles inserted in every access phase; range 0..15.

Ports:
- pclk  input  1  APB clock.
- presetn  input  1  asynchronous active-low reset.
- paddr  input  AddressWidth  byte address.
- psel  input  1  completer select.
- penable  input  1  access phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- pwdata  input  DataWidth  write data.
- pready  output  1  transfer complete.
- prdata  output  DataWidth  read data; valid only while pready=1 on a read.
- pslverr  output  1  error response; valid only while pready=1.
- err_count  output  8  saturating count of error responses.

Behaviour:
- Reset (presetn low, takes effect immediately, async): pready=0, prdata=0, pslverr=0, err_count=0, every memory word=0, FSM=IDLE, wait counter=0. Applies mid-transfer; the interrupted access has no effect.
- Derived constants:
  - Lsb = log2(DataWidth/8).
  - Index = paddr[Lsb +: log2(MemDepth)].
- Error conditions, evaluated on the setup-cycle address:
  - paddr[Lsb-1:0] != 0 (misaligned).
  - paddr >= MemDepth*DataWidth/8 (out of range).
- FSM is IDLE -> ACCESS -> IDLE; all outputs are registered.
- IDLE:
  - On an edge sampling psel=1, penable=0 (setup): latch addr, write, wdata and the error flag; go to ACCESS; load wait counter with WaitStates.
  - Same edge: pready<=1 if WaitStates==0. With WaitStates=0, pready is high in the first access cycle.
  - psel=1, penable=1 seen in IDLE (no setup phase) is a protocol violation: ignored, stay IDLE.
- ACCESS, no completion pending: each edge decrements the counter. pready<=1 on the edge where the counter goes 1->0. Access-phase latency is therefore WaitStates+1 cycles.
- Completion prep, on the same edge that sets pready<=1:
  - pslverr <= latched error flag.
  - On a read without error: prdata <= mem[Index].
  - On a read with error: prdata <= 0.
- ACCESS, completion (edge sampling psel=1, penable=1, pready=1):
  - Write without error: mem[Index] <= latched wdata.
  - Error: memory unchanged; err_count increments, saturating at 255.
  - pready, pslverr and prdata return to 0; go to IDLE.
- Back-to-back: the next setup cycle immediately follows completion and is accepted from IDLE. The minimum transfer is 2 cycles with no idle gap.
- psel deasserted during ACCESS before completion: abort, go to IDLE, pready/pslverr/prdata <= 0, no write, err_count unchanged.
- paddr/pwrite/pwdata changing during ACCESS: ignored, because the setup-cycle values are used.
- Read after write to the same word returns the new data, since the write commits at completion before the next setup.

Decomposition:
- Package apb3_completer_synth_pkg:
  - state_e typedef {IDLE, ACCESS}.
  - Function clog2-based helpers for Lsb/index width.
  - ErrCountWidth = 8.
- Sub-module apb3_completer_mem: MemDepth x DataWidth register array with async reset, one write port, one combinational read port. The FSM stays in the top module.

Test Plan (DataWidth=32, MemDepth=16, WaitStates=2 unless noted):
- Reset, then read 0x0 -> pready high exactly 3 cycles after penable rises; prdata=0x00000000; pslverr=0.
- Write 0xDEADBEEF to 0x3C, then read 0x3C -> prdata=0xDEADBEEF, pslverr=0. Read 0x38 -> 0x00000000.
- Write to 0x40 (out of range) and read 0x06 (misaligned) -> pslverr=1 on both; prdata=0; memory unchanged; err_count=2. 300 error accesses -> err_count=255.
- WaitStates=0: 8 back-to-back writes of i*0x11111111 to 0x00..0x1C with no idle cycle -> each completes in 2 cycles; readback matches each value.
- Abort and reset: psel dropped after 1 wait cycle of a write of 0x12345678 to 0x10 -> mem[4] stays 0, pready never high. presetn pulsed low during ACCESS -> all outputs 0 immediately and memory cleared.
